ps2_mouse_rx: RTL and testbench

Receives the raw PS/2 clock/data lines from the Basys3 mouse port in the 100 MHz system clock domain. It synchronises and deglitches the lines, deframes 11-bit PS/2 frames and checks parity. It assembles 3-byte movement packets and presents buttons and signed X/Y deltas with a one-cycle valid strobe. It sits directly upstream of the mouse click/direction logic, which consumes decoded packets instead of sampling the bus on the mouse clock.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_filter.sv | 75 +++++++
 rtl/ps2_mouse_rx.sv | 153 +++++++++++++++
 tb/tb_ps2_mouse_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_frame_state_t;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    // Byte-0 bit positions of a standard 3-byte movement packet
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XS    = 4;
    localparam int YS    = 5;
    localparam int XO    = 6;
    localparam int YO    = 7;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines, deglitches the clock and flags its falling edges.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_fall,
    output logic data_sync
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic [CW-1:0]          flt_cnt_reg;
    logic                   clk_filt_reg;
    logic                   clk_fall_reg;
    logic                   clk_s;

    // Idle bus is high, so the chain resets to 1 to avoid a phantom edge.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        clk_sync_reg[0]  <= 1'b1;
                        data_sync_reg[0] <= 1'b1;
                    end else begin
                        clk_sync_reg[0]  <= ps2_clk;
                        data_sync_reg[0] <= ps2_data;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        clk_sync_reg[gi]  <= 1'b1;
                        data_sync_reg[gi] <= 1'b1;
                    end else begin
                        clk_sync_reg[gi]  <= clk_sync_reg[gi-1];
                        data_sync_reg[gi] <= data_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign clk_s     = clk_sync_reg[SYNC_STAGES-1];
    assign data_sync = data_sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flt_cnt_reg  <= '0;
            clk_filt_reg <= 1'b1;
            clk_fall_reg <= 1'b0;
        end else begin
            clk_fall_reg <= 1'b0;
            if (clk_s == clk_filt_reg) begin
                flt_cnt_reg <= '0;
            end else if (flt_cnt_reg == CW'(FILTER_LEN - 1)) begin
                clk_filt_reg <= clk_s;
                clk_fall_reg <= ~clk_s;
                flt_cnt_reg  <= '0;
            end else begin
                flt_cnt_reg <= flt_cnt_reg + 1'b1;
            end
        end
    end

    assign clk_fall = clk_fall_reg;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: frame deframing, parity check, timeout and 3-byte packet assembly.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       pkt_valid,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_middle,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic             fall;
    logic             data_s;
    ps2_frame_state_t state_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic             parity_reg;
    logic [1:0]       idx_reg;
    logic [7:0]       b0_reg;
    logic [7:0]       b1_reg;
    logic [TW-1:0]    to_cnt_reg;
    logic             active;
    logic             timeout_hit;
    logic             frame_good;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_fall  (fall),
        .data_sync (data_s)
    );

    assign active      = (state_reg != ST_IDLE) || (idx_reg != 2'd0);
    // A clock fall in the terminal cycle is live bus activity, so it beats the timeout.
    assign timeout_hit = !fall && active && (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
    assign frame_good  = odd_parity_ok(shift_reg, parity_reg) && data_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            parity_reg    <= 1'b0;
            idx_reg       <= '0;
            b0_reg        <= '0;
            b1_reg        <= '0;
            to_cnt_reg    <= '0;
            pkt_valid     <= 1'b0;
            btn_left      <= 1'b0;
            btn_right     <= 1'b0;
            btn_middle    <= 1'b0;
            dx            <= '0;
            dy            <= '0;
            x_ovf         <= 1'b0;
            y_ovf         <= 1'b0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            pkt_valid     <= 1'b0;
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;

            if (fall || timeout_hit || !active) begin
                to_cnt_reg <= '0;
            end else begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end

            if (timeout_hit) begin
                state_reg <= ST_IDLE;
                idx_reg   <= '0;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (!data_s) begin
                            state_reg   <= ST_DATA;
                            bit_cnt_reg <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg   <= {data_s, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'(PS2_DATA_BITS - 1)) begin
                            state_reg <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_reg <= data_s;
                        state_reg  <= ST_STOP;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        if (frame_good) begin
                            rx_byte       <= shift_reg;
                            rx_byte_valid <= 1'b1;
                            case (idx_reg)
                                2'd0: begin
                                    // Byte 0 always carries bit 3 set; anything else is a resync discard.
                                    if (shift_reg[SYNC]) begin
                                        b0_reg  <= shift_reg;
                                        idx_reg <= 2'd1;
                                    end
                                end
                                2'd1: begin
                                    b1_reg  <= shift_reg;
                                    idx_reg <= 2'd2;
                                end
                                default: begin
                                    btn_left   <= b0_reg[BTN_L];
                                    btn_right  <= b0_reg[BTN_R];
                                    btn_middle <= b0_reg[BTN_M];
                                    x_ovf      <= b0_reg[XO];
                                    y_ovf      <= b0_reg[YO];
                                    dx         <= {b0_reg[XS], b1_reg};
                                    dy         <= {b0_reg[YS], shift_reg};
                                    pkt_valid  <= 1'b1;
                                    idx_reg    <= 2'd0;
                                end
                            endcase
                        end else begin
                            frame_err <= 1'b1;
                            idx_reg   <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: bit-banged PS/2 frames with hand-computed packet fields.
module tb_ps2_mouse_rx;

    localparam int T = 2000;
    localparam int H = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       pkt_valid, btn_left, btn_right, btn_middle, x_ovf, y_ovf;
    logic       rx_byte_valid, frame_err;
    logic [8:0] dx, dy;
    logic [7:0] rx_byte;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pkt_cnt = 0, byte_cnt = 0, err_cnt = 0, fall_cnt = 0;
    int err_cyc = 0, t_fall = 0;
    int p0, b0, e0, f0;

    ps2_mouse_rx #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .pkt_valid     (pkt_valid),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_middle    (btn_middle),
        .dx            (dx),
        .dy            (dy),
        .x_ovf         (x_ovf),
        .y_ovf         (y_ovf),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pkt_valid) pkt_cnt++;
        if (rx_byte_valid) byte_cnt++;
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (dut.fall) fall_cnt++;
        if (pkt_valid || rx_byte_valid || frame_err)
            $display("t=%0d pkt_valid=%0b rx_byte_valid=%0b frame_err=%0b rx_byte=%02h dx=%03h dy=%03h btn=%0b%0b%0b ovf=%0b%0b",
                     cyc, pkt_valid, rx_byte_valid, frame_err, rx_byte, dx, dy,
                     btn_middle, btn_right, btn_left, y_ovf, x_ovf);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(H);
        ps2_clk = 1'b0;
        t_fall = cyc;
        wait_cyc(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_parity);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_parity);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_cyc(60);
    endtask

    task automatic snap();
        p0 = pkt_cnt;
        b0 = byte_cnt;
        e0 = err_cnt;
        f0 = fall_cnt;
    endtask

    initial begin
        // Reset state
        wait_cyc(3);
        check("rst_strobes", {pkt_valid, rx_byte_valid, frame_err}, 3'b000);
        check("rst_fields", {btn_left, btn_right, btn_middle, x_ovf, y_ovf, dx, dy, rx_byte}, 0);
        reset = 1'b1;
        wait_cyc(20);

        // Basic packet: left button, dx=+5, byte2=FB with y sign clear
        snap();
        send_frame(8'h09, 1'b0);
        send_frame(8'h05, 1'b0);
        send_frame(8'hFB, 1'b0);
        check("p1_count", pkt_cnt - p0, 1);
        check("p1_bytes", byte_cnt - b0, 3);
        check("p1_btn", {btn_left, btn_right, btn_middle}, 3'b100);
        check("p1_dx", dx, 9'h005);
        check("p1_dy", dy, 9'h0FB);
        check("p1_ovf", {x_ovf, y_ovf}, 2'b00);
        check("p1_rx_byte", rx_byte, 8'hFB);
        check("p1_err", err_cnt - e0, 0);

        // Bad parity on byte 2, then a recovery packet with y sign set
        snap();
        send_frame(8'h09, 1'b0);
        send_frame(8'h05, 1'b0);
        send_frame(8'h10, 1'b1);
        check("par_err", err_cnt - e0, 1);
        check("par_nopkt", pkt_cnt - p0, 0);
        check("par_hold_dy", dy, 9'h0FB);
        send_frame(8'h29, 1'b0);
        send_frame(8'h05, 1'b0);
        send_frame(8'hFB, 1'b0);
        check("par_recover", pkt_cnt - p0, 1);
        check("p2_dx", dx, 9'h005);
        check("p2_dy", dy, 9'h1FB);

        // Stray byte without sync bit is discarded
        snap();
        send_frame(8'h05, 1'b0);
        send_frame(8'h0A, 1'b0);
        send_frame(8'h10, 1'b0);
        send_frame(8'h20, 1'b0);
        check("sync_count", pkt_cnt - p0, 1);
        check("sync_bytes", byte_cnt - b0, 4);
        check("sync_btn", {btn_left, btn_right, btn_middle}, 3'b010);
        check("sync_dx", dx, 9'h010);
        check("sync_dy", dy, 9'h020);

        // Timeout after two bytes
        snap();
        send_frame(8'h08, 1'b0);
        send_frame(8'h01, 1'b0);
        wait_cyc(T + 500);
        check("to_err", err_cnt - e0, 1);
        check("to_nopkt", pkt_cnt - p0, 0);
        check("to_latency", (err_cyc - t_fall >= T + 4) && (err_cyc - t_fall <= T + 8), 1);
        send_frame(8'h0C, 1'b0);
        send_frame(8'h03, 1'b0);
        send_frame(8'h04, 1'b0);
        check("to_recover", pkt_cnt - p0, 1);
        check("to_btn", {btn_left, btn_right, btn_middle}, 3'b001);
        check("to_dxdy", {dx, dy}, {9'h003, 9'h004});

        // Glitches shorter than the filter are ignored; one of filter length is an edge
        snap();
        ps2_clk = 1'b0; wait_cyc(2); ps2_clk = 1'b1; wait_cyc(30);
        ps2_clk = 1'b0; wait_cyc(2); ps2_clk = 1'b1; wait_cyc(30);
        ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(30);
        check("glitch_nofall", fall_cnt - f0, 0);
        check("glitch_quiet", (byte_cnt - b0) + (err_cnt - e0) + (pkt_cnt - p0), 0);
        check("glitch_hold", {dx, dy, btn_middle}, {9'h003, 9'h004, 1'b1});
        ps2_clk = 1'b0; wait_cyc(4); ps2_clk = 1'b1; wait_cyc(30);
        check("glitch4_fall", fall_cnt - f0, 1);
        check("glitch4_quiet", (byte_cnt - b0) + (err_cnt - e0), 0);

        // Overflow flags pass through unsaturated
        snap();
        send_frame(8'hC8, 1'b0);
        send_frame(8'h7F, 1'b0);
        send_frame(8'h80, 1'b0);
        check("ovf_count", pkt_cnt - p0, 1);
        check("ovf_flags", {x_ovf, y_ovf}, 2'b11);
        check("ovf_dxdy", {dx, dy}, {9'h07F, 9'h080});

        // Reset in the middle of byte 1
        send_frame(8'h08, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b0;
        wait_cyc(2);
        check("mrst_fields", {btn_left, btn_right, btn_middle, x_ovf, y_ovf, dx, dy, rx_byte}, 0);
        check("mrst_strobes", {pkt_valid, rx_byte_valid, frame_err}, 3'b000);
        reset = 1'b1;
        wait_cyc(20);
        snap();
        send_frame(8'h08, 1'b0);
        send_frame(8'h00, 1'b0);
        send_frame(8'h00, 1'b0);
        check("mrst_pkt", pkt_cnt - p0, 1);
        check("mrst_err", err_cnt - e0, 0);
        check("mrst_zero", {btn_left, btn_right, btn_middle, x_ovf, y_ovf, dx, dy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
